// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: writeback-select and load-type encodings plus the captured WB field bundle
package mem_wb_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  wr_addr;
    logic [1:0]  wb_sel;
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic [31:0] alu_res;
    logic [31:0] rdata;
    logic [31:0] pc8;
  } wb_fields_t;

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// mem_wb_stage_load_ext: picks the byte/half lane of a loaded word and sign/zero extends it
module mem_wb_stage_load_ext
  import mem_wb_stage_pkg::*;
#(
  parameter bit LITTLE_END = 1'b1
) (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  ld_type_i,
  output logic [31:0] data_o
);

  logic [1:0]  b_lane;
  logic        h_lane;
  logic [7:0]  b;
  logic [15:0] h;

  // big-endian lanes are the mirror image of little-endian ones
  assign b_lane = LITTLE_END ? addr_lo_i : ~addr_lo_i;
  assign h_lane = LITTLE_END ? addr_lo_i[1] : ~addr_lo_i[1];
  assign b = b_lane == 2'd0 ? rdata_i[7:0] :
             b_lane == 2'd1 ? rdata_i[15:8] :
             b_lane == 2'd2 ? rdata_i[23:16] : rdata_i[31:24];
  assign h = h_lane ? rdata_i[31:16] : rdata_i[15:0];

  // unknown load types fall back to a full word
  always_comb
    data_o = ld_type_i == LD_LH  ? {{16{h[15]}}, h} :
             ld_type_i == LD_LHU ? {16'h0, h} :
             ld_type_i == LD_LB  ? {{24{b[7]}}, b} :
             ld_type_i == LD_LBU ? {24'h0, b} : rdata_i;

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, load extension, writeback mux and retired counter
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter bit LITTLE_END = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_wr_addr,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_ld_type,
  input  logic [1:0]       mem_addr_lo,
  input  logic [31:0]      mem_alu_res,
  input  logic [31:0]      mem_rdata,
  input  logic [31:0]      mem_pc8,
  input  logic             stall,
  input  logic             flush,
  output logic             RegWrite,
  output logic [4:0]       WriteAddr,
  output logic [31:0]      WriteData,
  output logic             fwd_valid,
  output logic [CNT_W-1:0] retired
);

  wb_fields_t       mem_in, wb_q, wb_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [31:0]      ld_data, sel_data;

  assign mem_in = '{valid: mem_valid, reg_write: mem_reg_write, wr_addr: mem_wr_addr,
                    wb_sel: mem_wb_sel, ld_type: mem_ld_type, addr_lo: mem_addr_lo,
                    alu_res: mem_alu_res, rdata: mem_rdata, pc8: mem_pc8};

  // flush beats stall: a stalled slot that is flushed becomes a bubble and never retires
  always_comb begin
    wb_d = stall ? wb_q : mem_in;
    wb_d.valid = ~flush & (stall ? wb_q.valid : mem_valid);
    retired_d = retired_q + CNT_W'(wb_q.valid & ~stall);
  end

  // WB register and counter; reset drops any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
      retired_q <= '0;
    end else begin
      wb_q <= wb_d;
      retired_q <= retired_d;
    end
  end

  mem_wb_stage_load_ext #(.LITTLE_END(LITTLE_END)) u_load_ext (
    .rdata_i  (wb_q.rdata),
    .addr_lo_i(wb_q.addr_lo),
    .ld_type_i(wb_q.ld_type),
    .data_o   (ld_data)
  );

  assign sel_data  = wb_q.wb_sel == WB_SEL_LOAD ? ld_data :
                     wb_q.wb_sel == WB_SEL_LINK ? wb_q.pc8 : wb_q.alu_res;
  assign RegWrite  = wb_q.valid & wb_q.reg_write & |wb_q.wr_addr;
  assign WriteAddr = RegWrite ? wb_q.wr_addr : 5'd0;
  assign WriteData = RegWrite ? sel_data : 32'd0;
  assign fwd_valid = RegWrite;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and random checks of two mem_wb_stage configurations against a reference model
module tb_mem_wb_stage;

  logic        clk, rst, mem_valid, mem_reg_write, stall, flush;
  logic [4:0]  mem_wr_addr;
  logic [1:0]  mem_wb_sel, mem_addr_lo;
  logic [2:0]  mem_ld_type;
  logic [31:0] mem_alu_res, mem_rdata, mem_pc8;
  logic        a_rw, a_fv, b_rw, b_fv;
  logic [4:0]  a_wa, b_wa;
  logic [31:0] a_wd, b_wd, a_ret;
  logic [3:0]  b_ret;

  int checks = 0, errors = 0;

  bit          m_v, m_rw;
  logic [4:0]  m_wa;
  logic [1:0]  m_sel, m_lo;
  logic [2:0]  m_lt;
  logic [31:0] m_alu, m_rd, m_pc8, m_cnt;

  mem_wb_stage #(.CNT_W(32), .LITTLE_END(1'b1)) u_a (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_wr_addr(mem_wr_addr), .mem_wb_sel(mem_wb_sel), .mem_ld_type(mem_ld_type),
    .mem_addr_lo(mem_addr_lo), .mem_alu_res(mem_alu_res), .mem_rdata(mem_rdata),
    .mem_pc8(mem_pc8), .stall(stall), .flush(flush), .RegWrite(a_rw),
    .WriteAddr(a_wa), .WriteData(a_wd), .fwd_valid(a_fv), .retired(a_ret));

  mem_wb_stage #(.CNT_W(4), .LITTLE_END(1'b0)) u_b (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_wr_addr(mem_wr_addr), .mem_wb_sel(mem_wb_sel), .mem_ld_type(mem_ld_type),
    .mem_addr_lo(mem_addr_lo), .mem_alu_res(mem_alu_res), .mem_rdata(mem_rdata),
    .mem_pc8(mem_pc8), .stall(stall), .flush(flush), .RegWrite(b_rw),
    .WriteAddr(b_wa), .WriteData(b_wd), .fwd_valid(b_fv), .retired(b_ret));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_wd(input bit le);
    int unsigned lane;
    logic [31:0] w;
    if (!(m_v && m_rw && m_wa != 0)) return 32'd0;
    if (m_sel == 2) return m_pc8;
    if (m_sel != 1) return m_alu;
    if (m_lt == 1 || m_lt == 2) begin
      lane = le ? m_lo / 2 : 1 - m_lo / 2;
      w = m_rd >> (16 * lane);
      return m_lt == 1 ? 32'($signed(w[15:0])) : {16'h0, w[15:0]};
    end
    if (m_lt == 3 || m_lt == 4) begin
      lane = le ? m_lo : 3 - m_lo;
      w = m_rd >> (8 * lane);
      return m_lt == 3 ? 32'($signed(w[7:0])) : {24'h0, w[7:0]};
    end
    return m_rd;
  endfunction

  task automatic cycle();
    bit rw;
    @(posedge clk);
    if (rst) begin
      {m_v, m_rw, m_wa, m_sel, m_lt, m_lo, m_alu, m_rd, m_pc8, m_cnt} = '0;
    end else begin
      if (m_v && !stall) m_cnt++;
      if (flush) m_v = 0;
      else if (!stall) begin
        m_v = mem_valid; m_rw = mem_reg_write; m_wa = mem_wr_addr; m_sel = mem_wb_sel;
        m_lt = mem_ld_type; m_lo = mem_addr_lo; m_alu = mem_alu_res; m_rd = mem_rdata; m_pc8 = mem_pc8;
      end
    end
    #1;
    rw = m_v && m_rw && m_wa != 0;
    check("a_regwrite", a_rw, rw);
    check("a_fwd", a_fv, rw);
    check("a_addr", a_wa, rw ? m_wa : 0);
    check("a_data", a_wd, exp_wd(1));
    check("a_retired", a_ret, m_cnt);
    check("b_regwrite", b_rw, rw);
    check("b_fwd", b_fv, rw);
    check("b_addr", b_wa, rw ? m_wa : 0);
    check("b_data", b_wd, exp_wd(0));
    check("b_retired", b_ret, m_cnt % 16);
  endtask

  task automatic step(input bit r, input bit v, input bit rw, input logic [4:0] wa,
                      input logic [1:0] sel, input logic [2:0] lt, input logic [1:0] lo,
                      input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc8,
                      input bit st, input bit fl);
    rst = r; mem_valid = v; mem_reg_write = rw; mem_wr_addr = wa; mem_wb_sel = sel;
    mem_ld_type = lt; mem_addr_lo = lo; mem_alu_res = alu; mem_rdata = rd; mem_pc8 = pc8;
    stall = st; flush = fl;
    cycle();
  endtask

  task automatic idle(input bit r, input bit st, input bit fl);
    step(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, st, fl);
  endtask

  task automatic load(input logic [2:0] lt, input logic [1:0] lo, input logic [31:0] exp);
    step(0, 1, 1, 7, 1, lt, lo, 32'hDEAD_BEEF, 32'h80FF_7F01, 0, 0, 0);
    check("load_const", a_wd, exp);
  endtask

  initial begin
    {m_v, m_rw, m_wa, m_sel, m_lt, m_lo, m_alu, m_rd, m_pc8, m_cnt} = '0;
    idle(1, 0, 0);
    idle(1, 0, 0);
    check("rst_data", a_wd, 0);
    check("rst_retired", a_ret, 0);
    step(0, 1, 1, 5, 0, 0, 0, 32'h1234_5678, 0, 0, 0, 0);
    check("alu_data", a_wd, 32'h1234_5678);
    check("alu_addr", a_wa, 5);
    idle(0, 0, 0);
    check("alu_retired", a_ret, 1);
    load(3, 0, 32'h0000_0001);
    load(3, 3, 32'hFFFF_FF80);
    load(4, 3, 32'h0000_0080);
    load(1, 2, 32'hFFFF_80FF);
    load(2, 0, 32'h0000_7F01);
    load(0, 1, 32'h80FF_7F01);
    load(5, 2, 32'h80FF_7F01);
    step(0, 1, 1, 31, 2, 0, 0, 32'h1, 0, 32'h0040_0008, 0, 0);
    check("link_data", a_wd, 32'h0040_0008);
    step(0, 1, 1, 0, 2, 0, 0, 32'h1, 0, 32'h0040_0008, 0, 0);
    check("link_r0_we", a_rw, 0);
    check("link_r0_data", a_wd, 0);
    step(0, 1, 1, 9, 0, 0, 0, 32'hCAFE_0009, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 10, 0, 0, 0, 32'h0BAD_0010, 0, 0, 1, 0);
      check("stall_hold", a_wd, 32'hCAFE_0009);
    end
    idle(0, 0, 0);
    step(0, 1, 1, 11, 0, 0, 0, 32'h1111_0011, 0, 0, 0, 0);
    step(0, 1, 1, 12, 0, 0, 0, 32'h2222_0012, 0, 0, 1, 1);
    check("flush_stall_we", a_rw, 0);
    idle(1, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 1, 5'(i + 1), 0, 0, 0, i, 0, 0, 0, 0);
    idle(0, 0, 0);
    check("wrap_retired", {28'h0, b_ret}, 1);
    step(0, 1, 1, 3, 0, 0, 0, 32'h3333_0003, 0, 0, 0, 0);
    idle(1, 0, 0);
    check("rst_mid_we", a_rw, 0);
    check("rst_mid_retired", a_ret, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(99) < 2, $urandom_range(99) < 80, $urandom_range(99) < 85,
           5'($urandom), 2'($urandom), 3'($urandom_range(5)), 2'($urandom),
           $urandom, $urandom, $urandom, $urandom_range(99) < 20, $urandom_range(99) < 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
